// File: rtl/addr_entry_issue.sv
// Pops address entries from the FIFO, issues them on a req/ack memory port and returns
// in-order tagged responses; one-cycle pop-to-request latency, pops gated by ack and credit.
module addr_entry_issue #(
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 3,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1),
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_valid,
   input  logic [ADDR_WIDTH-1:0] fifo_addr,
   input  logic [ID_WIDTH-1:0]   fifo_id,
   input  logic                  fifo_we,
   output logic                  fifo_pop,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   output logic                  resp_valid,
   output logic [ID_WIDTH-1:0]   resp_id,
   output logic                  resp_we,
   output logic [CNT_W-1:0]      outstanding,
   output logic                  idle
);

   logic                  stg_vld_q, stg_vld_d;
   logic [ADDR_WIDTH-1:0] stg_addr_q, stg_addr_d;
   logic [ID_WIDTH-1:0]   stg_id_q, stg_id_d;
   logic                  stg_we_q, stg_we_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [ID_WIDTH-1:0]   tq_id_q [MAX_OUTSTANDING];
   logic [ID_WIDTH-1:0]   tq_id_d [MAX_OUTSTANDING];
   logic                  tq_we_q [MAX_OUTSTANDING];
   logic                  tq_we_d [MAX_OUTSTANDING];
   logic                  credit_ok;
   logic                  push;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   always_comb begin
      // The held request counts against credit; a same-cycle response does not.
      credit_ok = ({1'b0, cnt_q} + (CNT_W+1)'(stg_vld_q)) < (CNT_W+1)'(MAX_OUTSTANDING);
      fifo_pop  = fifo_valid & (~stg_vld_q | mem_ack) & credit_ok;
      push      = stg_vld_q & mem_ack;

      stg_vld_d  = stg_vld_q;
      stg_addr_d = stg_addr_q;
      stg_id_d   = stg_id_q;
      stg_we_d   = stg_we_q;
      if (fifo_pop) begin
         stg_vld_d  = 1'b1;
         stg_addr_d = fifo_addr;
         stg_id_d   = fifo_id;
         stg_we_d   = fifo_we;
      end else if (mem_ack) begin
         stg_vld_d = 1'b0;
      end

      cnt_d = cnt_q;
      case ({push, mem_rvalid})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      wr_ptr_d = push       ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = mem_rvalid ? next_ptr(rd_ptr_q) : rd_ptr_q;

      tq_id_d = tq_id_q;
      tq_we_d = tq_we_q;
      if (push) begin
         tq_id_d[wr_ptr_q] = stg_id_q;
         tq_we_d[wr_ptr_q] = stg_we_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld_q <= 1'b0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         stg_vld_q <= stg_vld_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      stg_addr_q <= stg_addr_d;
      stg_id_q   <= stg_id_d;
      stg_we_q   <= stg_we_d;
      tq_id_q    <= tq_id_d;
      tq_we_q    <= tq_we_d;
   end

   assign mem_req     = stg_vld_q;
   assign mem_addr    = stg_addr_q;
   assign mem_we      = stg_we_q;
   assign resp_valid  = mem_rvalid;
   assign resp_id     = tq_id_q[rd_ptr_q];
   assign resp_we     = tq_we_q[rd_ptr_q];
   assign outstanding = cnt_q;
   assign idle        = ~fifo_valid & ~stg_vld_q & (cnt_q == '0);

   logic                  stall_q;
   logic [ADDR_WIDTH-1:0] prev_addr_q;
   logic [ID_WIDTH-1:0]   prev_id_q;
   logic                  prev_we_q;

   always_ff @(posedge clk) begin
      stall_q     <= ~rst & stg_vld_q & ~mem_ack;
      prev_addr_q <= stg_addr_q;
      prev_id_q   <= stg_id_q;
      prev_we_q   <= stg_we_q;
      if (rst) begin
         assert (mem_rvalid !== 1'b1) else $error("mem_rvalid during reset");
      end else begin
         assert (!(mem_ack && !stg_vld_q)) else $error("mem_ack without mem_req");
         assert (!(mem_rvalid && cnt_q == '0)) else $error("mem_rvalid with nothing outstanding");
         assert (!(fifo_pop && !fifo_valid)) else $error("fifo_pop while fifo empty");
         if (stall_q) begin
            assert (stg_vld_q && stg_addr_q == prev_addr_q && stg_id_q == prev_id_q
                    && stg_we_q == prev_we_q)
               else $error("request fields changed while stalled");
         end
      end
   end

endmodule

// File: tb/tb_addr_entry_issue.sv
// Directed bench: MAX_OUTSTANDING=4 instance for issue/credit/reset, MAX_OUTSTANDING=3 for wrap.
module tb_addr_entry_issue;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        fv = 0, fw = 0, ack = 0, rv = 0;
   logic [31:0] fa = 0;
   logic [2:0]  fi = 0;
   logic        pop, req, mwe, rsv, rwe, idle;
   logic [31:0] maddr;
   logic [2:0]  rid;
   logic [2:0]  outs;

   logic        b_fv = 0, b_fw = 0, b_ack = 0, b_rv = 0;
   logic [31:0] b_fa = 0;
   logic [2:0]  b_fi = 0;
   logic        b_pop, b_req, b_mwe, b_rsv, b_rwe, b_idle;
   logic [31:0] b_maddr;
   logic [2:0]  b_rid;
   logic [1:0]  b_outs;

   addr_entry_issue #(.ADDR_WIDTH(32), .ID_WIDTH(3), .MAX_OUTSTANDING(4)) u_a (
      .clk(clk), .rst(rst), .fifo_valid(fv), .fifo_addr(fa), .fifo_id(fi), .fifo_we(fw),
      .fifo_pop(pop), .mem_req(req), .mem_addr(maddr), .mem_we(mwe), .mem_ack(ack),
      .mem_rvalid(rv), .resp_valid(rsv), .resp_id(rid), .resp_we(rwe),
      .outstanding(outs), .idle(idle));

   addr_entry_issue #(.ADDR_WIDTH(32), .ID_WIDTH(3), .MAX_OUTSTANDING(3)) u_b (
      .clk(clk), .rst(rst), .fifo_valid(b_fv), .fifo_addr(b_fa), .fifo_id(b_fi), .fifo_we(b_fw),
      .fifo_pop(b_pop), .mem_req(b_req), .mem_addr(b_maddr), .mem_we(b_mwe), .mem_ack(b_ack),
      .mem_rvalid(b_rv), .resp_valid(b_rsv), .resp_id(b_rid), .resp_we(b_rwe),
      .outstanding(b_outs), .idle(b_idle));

   int checks = 0;
   int errors = 0;
   int issues = 0;

   logic [31:0] q_addr [0:15];
   logic [2:0]  q_id   [0:15];
   logic        q_we   [0:15];
   int qn = 0;
   int qh = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_entry(input logic [31:0] a, input logic [2:0] i, input logic w);
      q_addr[qn] = a;
      q_id[qn]   = i;
      q_we[qn]   = w;
      qn++;
   endtask

   // One cycle on instance A: drive at negedge, settle, then update the FIFO model.
   task automatic step(input logic a, input logic r);
      @(negedge clk);
      fv = (qh < qn);
      if (qh < qn) begin
         fa = q_addr[qh];
         fi = q_id[qh];
         fw = q_we[qh];
      end
      ack = a & req;
      rv  = r;
      #1;
      if (ack) issues++;
      if (pop) qh++;
   endtask

   task automatic single_read(input logic [31:0] a, input logic [2:0] i, input logic w);
      push_entry(a, i, w);
      step(0, 0);
      chk("sr_pop", pop, 1);
      chk("sr_req0", req, 0);
      chk("sr_outs0", outs, 0);
      chk("sr_busy", idle, 0);
      step(1, 0);
      chk("sr_req", req, 1);
      chk("sr_addr", maddr, a);
      chk("sr_we", mwe, w);
      chk("sr_pop_once", pop, 0);
      step(0, 0);
      chk("sr_req_clr", req, 0);
      chk("sr_outs1", outs, 1);
      step(0, 0);
      step(0, 0);
      step(0, 1);
      chk("sr_rsv", rsv, 1);
      chk("sr_rid", rid, i);
      chk("sr_rwe", rwe, w);
      step(0, 0);
      chk("sr_outs_end", outs, 0);
      chk("sr_idle", idle, 1);
      chk("sr_rsv_end", rsv, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", req, 0);
      chk("rst_pop", pop, 0);
      chk("rst_rsv", rsv, 0);
      chk("rst_outs", outs, 0);
      chk("rst_idle", idle, 1);
      rst = 1'b0;

      single_read(32'h1000, 3'd2, 1'b0);

      // Ack stall with three entries queued
      push_entry(32'h2000, 3'd3, 1'b1);
      push_entry(32'h2004, 3'd4, 1'b0);
      push_entry(32'h2008, 3'd5, 1'b1);
      step(0, 0);
      chk("stall_first_pop", pop, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0);
         chk("stall_addr", maddr, 32'h2000);
         chk("stall_pop", pop, 0);
         chk("stall_req", req, 1);
      end
      step(1, 0);
      chk("stall_ack_we", mwe, 1);
      chk("stall_ack_pop", pop, 1);
      step(0, 0);
      chk("stall_next_req", req, 1);
      chk("stall_next_addr", maddr, 32'h2004);
      chk("stall_outs", outs, 1);
      step(1, 0);
      chk("stall_pop3", pop, 1);
      step(1, 0);
      chk("stall_addr3", maddr, 32'h2008);
      step(0, 0);
      chk("stall_outs3", outs, 3);
      step(0, 1);
      chk("stall_rid0", rid, 3);
      chk("stall_rwe0", rwe, 1);
      step(0, 1);
      chk("stall_rid1", rid, 4);
      chk("stall_rwe1", rwe, 0);
      step(0, 1);
      chk("stall_rid2", rid, 5);
      chk("stall_rwe2", rwe, 1);
      step(0, 0);
      chk("stall_idle", idle, 1);

      // Credit limit at 4 outstanding
      for (int i = 0; i < 6; i++) push_entry(32'h3000 + 32'(4 * i), 3'(i), i[0]);
      issues = 0;
      for (int i = 0; i < 7; i++) step(1, 0);
      chk("cred_issues", issues, 4);
      chk("cred_outs", outs, 4);
      chk("cred_pop", pop, 0);
      chk("cred_req", req, 0);
      step(1, 1);
      chk("cred_rv_nocredit", pop, 0);
      chk("cred_rid", rid, 0);
      step(1, 0);
      chk("cred_pop_after", pop, 1);
      step(1, 0);
      chk("cred_addr4", maddr, 32'h3010);
      chk("cred_pop_blocked", pop, 0);
      step(1, 0);
      chk("cred_issues5", issues, 5);
      chk("cred_outs5", outs, 4);

      // Drain to cnt=2, then simultaneous ack and rvalid
      step(0, 1);
      chk("drain_rid1", rid, 1);
      step(0, 1);
      chk("drain_rid2", rid, 2);
      chk("drain_pop5", pop, 1);
      step(1, 1);
      chk("sim_outs_before", outs, 2);
      chk("sim_rid_oldest", rid, 3);
      chk("sim_ack", ack, 1);
      step(0, 0);
      chk("sim_outs_after", outs, 2);
      chk("sim_req_clr", req, 0);
      step(0, 1);
      chk("drain_rid4", rid, 4);
      step(0, 1);
      chk("drain_rid5", rid, 5);
      chk("drain_rwe5", rwe, 1);
      step(0, 0);
      chk("drain_idle", idle, 1);

      // Wrap and order on the depth-3 instance
      begin
         int b_next = 0;
         int b_exp  = 0;
         int ack_t[$];
         for (int c = 0; c < 80 && b_exp < 8; c++) begin
            @(negedge clk);
            b_fv  = (b_next < 8);
            b_fa  = 32'h4000 + 32'(b_next);
            b_fi  = b_next[2:0];
            b_fw  = b_next[0];
            b_ack = b_req;
            b_rv  = (ack_t.size() > 0) && (c >= ack_t[0] + 2);
            #1;
            if (b_rv) begin
               chk("wrap_rid", b_rid, b_exp[2:0]);
               chk("wrap_rwe", b_rwe, b_exp[0]);
               void'(ack_t.pop_front());
               b_exp++;
            end
            if (b_ack) ack_t.push_back(c);
            if (b_pop) b_next++;
         end
         @(negedge clk);
         b_fv  = 0;
         b_ack = 0;
         b_rv  = 0;
         #1;
         chk("wrap_count", b_exp, 8);
         chk("wrap_idle", b_idle, 1);
      end

      // Reset mid-flight with mem_req held and two outstanding
      push_entry(32'h5000, 3'd6, 1'b0);
      push_entry(32'h5004, 3'd7, 1'b1);
      push_entry(32'h5008, 3'd1, 1'b0);
      step(0, 0);
      step(1, 0);
      step(1, 0);
      step(0, 0);
      chk("mid_outs", outs, 2);
      chk("mid_req", req, 1);
      @(negedge clk);
      rst = 1'b1;
      ack = 1'b0;
      fv  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", req, 0);
      chk("mid_rst_outs", outs, 0);
      chk("mid_rst_rsv", rsv, 0);

      single_read(32'h6000, 3'd5, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
